// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built from one external 4-bit ripple-carry adder, stepped one
// nibble per clock (LSB first) behind valid/ready handshakes on both sides.
module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic [3:0]       nib_a,
   output logic [3:0]       nib_b,
   output logic             nib_cin,
   input  logic [3:0]       nib_s,
   input  logic             nib_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
         $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 8");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   // NOTE: every _d starts as its _q so no path through the case leaves a
   // variable unassigned; that is what keeps this block free of latches.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               carry_d = op_cin;
               idx_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            sum_d[4*idx_q +: 4] = nib_s;
            carry_d = nib_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               // Signed overflow: like-signed operands producing a result of the other sign.
               cout_d  = nib_cout;
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops
   // update together from values sampled before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // The external adder is combinational, so its operands come straight off the registers.
   always_comb begin
      nib_a   = 4'h0;
      nib_b   = 4'h0;
      nib_cin = 1'b0;
      if (state_q == ADD) begin
         nib_a   = a_q[4*idx_q +: 4];
         nib_b   = b_q[4*idx_q +: 4];
         nib_cin = carry_q;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that computes a WIDTH-bit add by driving the team's existing 4-bit ripple-carry adder one nibble per clock, LSB nibble first.
- Sits directly around that adder. It feeds the adder's nibble operands and carry-in, and consumes the adder's sum and carry-out. The carry is registered between nibbles.
- Gives a wide adder with only one 4-bit adder instance, behind valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8. Derived NIBBLES = WIDTH/4.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- op_cin  input  1  carry into bit 0
- nib_a  output  4  nibble of A to the external 4-bit adder
- nib_b  output  4  nibble of B to the external 4-bit adder
- nib_cin  output  1  carry-in to the external 4-bit adder
- nib_s  input  4  sum returned by the external 4-bit adder
- nib_cout  input  1  carry-out returned by the external 4-bit adder
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB
- ovf  output  1  two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high; it forces all state immediately.
- Reset values:
  - state=IDLE, nibble index=0, carry reg=0.
  - Operand regs and sum/cout/ovf regs all 0; out_valid=0.
  - nib_a=0, nib_b=0, nib_cin=0.
  - in_ready=1, since it is combinational (state==IDLE).
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture op_a, op_b into operand regs; carry reg<=op_cin; idx<=0; go to ADD.
- State ADD:
  - Combinational drive: nib_a=a_reg[4*idx+:4], nib_b=b_reg[4*idx+:4], nib_cin=carry reg.
  - Each edge: sum_reg[4*idx+:4]<=nib_s; carry reg<=nib_cout; idx<=idx+1.
  - On the edge where idx==NIBBLES-1: cout<=nib_cout; ovf<=(a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (nib_s[3]!=a_reg[WIDTH-1]); go to DONE.
  - in_ready=0 throughout.
- State DONE:
  - out_valid=1. sum, cout and ovf are held stable while out_ready=0 (backpressure of any length).
  - On out_valid&&out_ready: go to IDLE. sum/cout/ovf keep their last values until the next completion.
- Outside ADD: nib_a=0, nib_b=0, nib_cin=0.
- Latency: if operands are accepted at edge t, out_valid is high in the cycle following edge t+NIBBLES.
- Throughput: at most one operation per NIBBLES+2 cycles.
  - No new accept is possible in the handoff cycle, because in_ready=0 in DONE.
  - The earliest next accept is the cycle after out_ready handshake.
- Operand changes: op_a, op_b and op_cin may change freely after acceptance; only the registered copies are used.
- Flag rules: ovf is computed for signed interpretation; cout is the unsigned carry. Both are valid only with out_valid.
- Reset mid-operation (ADD or DONE): the result is discarded, all outputs return to reset values, and no out_valid is produced for that operation.
- External adder: treated as purely combinational. nib_s and nib_cout must settle within the same cycle nib_a/nib_b/nib_cin are driven; the block adds no extra pipeline delay.
- Illegal WIDTH: a WIDTH that is not a multiple of 4 is a compile-time error via a generate-time check.

Test Plan:
All cases use WIDTH=16 with the real 4-bit ripple-carry adder attached.
- Basic add: 0x1234 + 0x0FFF, cin=0 -> sum=0x2233, cout=0, ovf=0. out_valid rises exactly 4 edges after acceptance.
- Full carry propagation: 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. nib_cin=1 is seen on nibbles 1..3.
- Signed overflow: 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1. Also 0x8000 + 0x8000 -> sum=0x0000, cout=1, ovf=1.
- Carry-in only: 0x0000 + 0x0000, cin=1 -> sum=0x0001, cout=0. Then 0xFFFF + 0x0000, cin=1 -> sum=0x0000, cout=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles: sum/cout/ovf stay stable, in_ready=0.
  - Then pulse out_ready with in_valid held high and the next operands waiting: the next accept occurs 1 cycle after the handshake.
- Reset mid-ADD: assert rst asynchronously during nibble 2 -> out_valid=0, in_ready=1, nib_*=0 immediately. A fresh 0x0001 + 0x0001 afterwards -> 0x0002.
